// File: rtl/mem_pkg.sv
// Shared definitions for the memory responder: FSM encoding, bus widths, default depth.
package mem_pkg;

  localparam int DATA_W    = 32;
  localparam int BUS_ADDR_W = 32;
  localparam int DEPTH_DEF = 256;
  localparam int CNT_W     = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Range check on the full bus address; never on a truncated index.
  function automatic logic addr_in_range(input logic [BUS_ADDR_W-1:0] addr,
                                         input int unsigned depth);
    return (addr < BUS_ADDR_W'(depth));
  endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Request/response handshake bundle between the core's memory wrapper and the responder.
interface mem_responder_if;
  import mem_pkg::*;

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [BUS_ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0]     req_wdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_W-1:0]     rsp_rdata;
  logic                  rsp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/mem_responder_word_array.sv
// DEPTH x 32 word storage: synchronous write, combinational read, deliberately not reset
// so contents survive a responder reset.
module mem_word_array
  import mem_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_idx,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  // Word write on the clock edge; no reset on purpose.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_idx] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_idx];

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: accepts one word request, waits WAIT_CYCLES, performs the
// access and holds the response until the initiator takes it.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | ready for a request (req_ready=1)
// ST_WAIT | request latched, counting down wait states; access at cnt==0
// ST_RESP | response registered, held until rsp_ready
module mem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH       = DEPTH_DEF,
  parameter int ADDR_W      = $clog2(DEPTH),
  parameter int WAIT_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  mem_responder_if.slave   bus,
  output logic             busy
);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [CNT_W-1:0]      r_cnt;
  logic [CNT_W-1:0]      w_cnt_nxt;
  logic                  w_latch;
  logic                  w_access;
  logic                  w_rsp_clr;

  logic                  r_write;
  logic [BUS_ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0]     r_wdata;

  logic                  r_rsp_valid;
  logic [DATA_W-1:0]     r_rsp_rdata;
  logic                  r_rsp_err;

  logic                  w_req_ready;
  logic                  w_in_range;
  logic                  w_we;
  logic [ADDR_W-1:0]     w_idx;
  logic [DATA_W-1:0]     w_mem_rdata;

  // Combinational from state so req_ready/busy follow an async reset immediately.
  assign w_req_ready   = (r_state == ST_IDLE);
  assign bus.req_ready = w_req_ready;
  assign busy          = ~w_req_ready;

  assign w_in_range = addr_in_range(r_addr, DEPTH);
  assign w_idx      = r_addr[ADDR_W-1:0];
  // Write only fires on the access cycle, so a reset during WAIT abandons it.
  assign w_we       = w_access & r_write & w_in_range;

  mem_word_array #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk     (clk),
    .i_we    (w_we),
    .i_idx   (w_idx),
    .i_wdata (r_wdata),
    .o_rdata (w_mem_rdata)
  );

  // State register and wait-state counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state, counter and datapath strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_latch     = 1'b0;
    w_access    = 1'b0;
    w_rsp_clr   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.req_valid) begin
          w_latch     = 1'b1;
          w_cnt_nxt   = CNT_W'(WAIT_CYCLES);
          w_state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end else begin
          w_access    = 1'b1;
          w_state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        if (r_rsp_valid && bus.rsp_ready) begin
          w_rsp_clr   = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Request latch; the req_* inputs are only looked at on the accepting edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_write <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_latch) begin
      r_write <= bus.req_write;
      r_addr  <= bus.req_addr;
      r_wdata <= bus.req_wdata;
    end
  end

  // Response registers: loaded on the access cycle, cleared on handshake.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else if (w_access) begin
      r_rsp_valid <= 1'b1;
      r_rsp_rdata <= (w_in_range && !r_write) ? w_mem_rdata : '0;
      r_rsp_err   <= ~w_in_range;
    end else if (w_rsp_clr) begin
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end
  end

  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign bus.rsp_err   = r_rsp_err;

endmodule
